// File: rtl/dm_pkg.sv
// Shared data-memory definitions: DMType encodings, LSU FSM states, request decode helpers.
package dm_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBeat = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

    // Unsigned types only exist for loads.
    function automatic logic type_illegal(input logic we, input logic [2:0] t);
        case (t)
            DM_B, DM_H, DM_W: return 1'b0;
            DM_BU, DM_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] t, input logic [1:0] a);
        case (t)
            DM_H, DM_HU: return a[0];
            DM_W:        return a != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    // Index of the final byte beat of a split access.
    function automatic logic [1:0] last_beat(input logic [2:0] t);
        return (t == DM_W) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/lsu_split_if.sv
// Request/response and data-memory signal bundle for the load/store unit.
interface lsu_split_if #(
    parameter int unsigned ADDR_W = 8
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              dm_wr;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_din;
    logic [2:0]        dm_type;
    logic [31:0]       dm_dout;

    // CPU and memory side of the bundle.
    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_wr, dm_addr, dm_din, dm_type
    );

    // Load/store unit side of the bundle.
    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, dm_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_wr, dm_addr, dm_din, dm_type
    );

endinterface

// File: rtl/lsu_extend.sv
// Load result extension: takes four little-endian bytes and sign/zero extends by DMType.
module lsu_extend
    import dm_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  dtype,
    output logic [31:0] ext
);

    always_comb begin
        ext = '0;
        case (dtype)
            DM_B:    ext = {{24{data[7]}}, data[7:0]};
            DM_H:    ext = {{16{data[15]}}, data[15:0]};
            DM_W:    ext = data;
            DM_BU:   ext = {24'b0, data[7:0]};
            DM_HU:   ext = {16'b0, data[15:0]};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit: single-beat aligned accesses, byte-beat splitting of misaligned H/W accesses.
// Define LSU_MISALIGN_TRAP_EN to report misaligned requests as errors instead of splitting them.
module lsu_split
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input logic         clk,
    input logic         rstn,
    lsu_split_if.slave  bus
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TrapMisalign = 1'b1;
`else
    localparam bit TrapMisalign = 1'b0;
`endif

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              split_q, split_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        k_q, k_d, k_next;
    logic [31:0]       buf_q, buf_d;
    logic [31:0]       asm_data, ext_data;
    logic              mis;
    logic              accept;

    logic              dm_wr_q, dm_wr_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [31:0]       dm_din_q, dm_din_d;
    logic [2:0]        dm_type_q, dm_type_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    assign bus.req_ready = (state_q == StIdle) && rstn;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.dm_wr     = dm_wr_q;
    assign bus.dm_addr   = dm_addr_q;
    assign bus.dm_din    = dm_din_q;
    assign bus.dm_type   = dm_type_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    lsu_extend u_extend (
        .data  (asm_data),
        .dtype (type_q),
        .ext   (ext_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        split_d     = split_q;
        last_d      = last_q;
        k_d         = k_q;
        buf_d       = buf_q;
        dm_wr_d     = dm_wr_q;
        dm_addr_d   = dm_addr_q;
        dm_din_d    = dm_din_q;
        dm_type_d   = dm_type_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        k_next      = k_q + 2'd1;
        mis         = is_misaligned(bus.req_type, bus.req_addr[1:0]);

        // Current beat's read data merged into the bytes gathered so far.
        asm_data = split_q ? buf_q : bus.dm_dout;
        if (split_q) begin
            asm_data[{k_q, 3'b000} +: 8] = bus.dm_dout[7:0];
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    type_d  = bus.req_type;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    k_d     = 2'd0;
                    buf_d   = '0;
                    if (type_illegal(bus.req_we, bus.req_type) || (TrapMisalign && mis)) begin
                        state_d     = StResp;
                        split_d     = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = StBeat;
                        split_d   = mis;
                        last_d    = mis ? last_beat(bus.req_type) : 2'd0;
                        dm_wr_d   = bus.req_we;
                        dm_addr_d = bus.req_addr;
                        if (mis) begin
                            dm_type_d = bus.req_we ? DM_B : DM_BU;
                            dm_din_d  = {24'b0, bus.req_wdata[7:0]};
                        end else begin
                            dm_type_d = bus.req_type;
                            dm_din_d  = bus.req_wdata;
                        end
                    end
                end
            end
            StBeat: begin
                buf_d = asm_data;
                if (k_q == last_q) begin
                    state_d     = StResp;
                    dm_wr_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? 32'b0 : ext_data;
                end else begin
                    k_d       = k_next;
                    dm_addr_d = addr_q + ADDR_W'(k_next);
                    dm_din_d  = {24'b0, wdata_q[{k_next, 3'b000} +: 8]};
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                dm_wr_d = 1'b0;
            end
        endcase
    end

    // Reset also aborts an in-flight split: no further beats and no response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            type_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            split_q     <= 1'b0;
            last_q      <= '0;
            k_q         <= '0;
            buf_q       <= '0;
            dm_wr_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_din_q    <= '0;
            dm_type_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            split_q     <= split_d;
            last_q      <= last_d;
            k_q         <= k_d;
            buf_q       <= buf_d;
            dm_wr_q     <= dm_wr_d;
            dm_addr_q   <= dm_addr_d;
            dm_din_q    <= dm_din_d;
            dm_type_q   <= dm_type_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
